multi_cycle_ctrl: RTL

- Sequencing control FSM for the multi-cycle MIPS datapath; replaces the single-cycle opcode decoder with a per-state Moore controller.
- Consumes `op` from the instruction register and drives the PC, memory, IR, register-file and ALU-mux enables, one step per cycle.
- Supports R-type, lw, sw, beq and j.
- Memory accesses stall on a `mem_ready` handshake.

---
 rtl/multi_cycle_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
// Moore sequencing controller for the multi-cycle MIPS datapath. One state
// per datapath step; R-type, lw, sw, beq and j are supported. The IF and
// memory states hold on a mem_ready handshake. While rst_n is low, every
// write/strobe output is forced low combinationally so nothing architectural
// can change during reset.

module multi_cycle_ctrl #(
  parameter logic [5:0] OP_R   = 6'h00,
  parameter logic [5:0] OP_LW  = 6'h23,
  parameter logic [5:0] OP_SW  = 6'h2B,
  parameter logic [5:0] OP_BEQ = 6'h04,
  parameter logic [5:0] OP_J   = 6'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  // State codes are visible on the debug port, so they are fixed explicitly.
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LW_WB   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BEQ     = 4'd8,
    S_JMP     = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Decoded (pre-gating) control values.
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic [1:0] w_pc_source;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_instr_done;
  logic       w_illegal_op;

  // True when the opcode is one this controller knows how to sequence.
  function automatic logic f_is_legal_op(input logic [5:0] opc);
    return (opc == OP_R)  || (opc == OP_LW) || (opc == OP_SW) ||
           (opc == OP_BEQ) || (opc == OP_J);
  endfunction

  // State register; asynchronous reset returns the controller to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; op is only looked at in ID and MEM_ADR.
  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF: begin
        if (mem_ready) w_next_state = S_ID;
        else           w_next_state = S_IF;
      end
      S_ID: begin
        if ((op == OP_LW) || (op == OP_SW)) w_next_state = S_MEM_ADR;
        else if (op == OP_R)                w_next_state = S_R_EX;
        else if (op == OP_BEQ)              w_next_state = S_BEQ;
        else if (op == OP_J)                w_next_state = S_JMP;
        else                                w_next_state = S_IF;
      end
      S_MEM_ADR: begin
        // op cannot change after fetch, so only lw/sw reach here; anything
        // else is treated as a dead end and refetches.
        if (op == OP_LW)      w_next_state = S_MEM_RD;
        else if (op == OP_SW) w_next_state = S_MEM_WR;
        else                  w_next_state = S_IF;
      end
      S_MEM_RD: begin
        if (mem_ready) w_next_state = S_LW_WB;
        else           w_next_state = S_MEM_RD;
      end
      S_LW_WB:  w_next_state = S_IF;
      S_MEM_WR: begin
        if (mem_ready) w_next_state = S_IF;
        else           w_next_state = S_MEM_WR;
      end
      S_R_EX:   w_next_state = S_R_WB;
      S_R_WB:   w_next_state = S_IF;
      S_BEQ:    w_next_state = S_IF;
      S_JMP:    w_next_state = S_IF;
      default:  w_next_state = S_IF;
    endcase
  end

  // Moore output decode; mem_ready and op only qualify handshake/flag bits.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 2'b00;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;
    case (r_state)
      S_IF: begin
        // PC+4 is computed every fetch cycle but only committed with the IR.
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
      end
      S_ID: begin
        // Branch target precomputed into ALUOut while decoding.
        w_alu_src_b  = 2'b11;
        w_illegal_op = ~f_is_legal_op(op);
      end
      S_MEM_ADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_LW_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        // Write strobe held through stalls; the instruction ends on accept.
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = mem_ready;
      end
      S_R_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_instr_done    = 1'b1;
      end
      S_JMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = 2'b10;
        w_instr_done = 1'b1;
      end
      default: begin
        w_pc_write = 1'b0;
      end
    endcase
  end

  // Strobes are masked by rst_n so a reset asserted between edges kills any
  // in-flight write immediately rather than at the next clock.
  assign PCWrite     = w_pc_write      & rst_n;
  assign PCWriteCond = w_pc_write_cond & rst_n;
  assign IRWrite     = w_ir_write      & rst_n;
  assign RegWrite    = w_reg_write     & rst_n;
  assign MemWrite    = w_mem_write     & rst_n;
  assign MemRead     = w_mem_read      & rst_n;
  assign instr_done  = w_instr_done    & rst_n;
  assign illegal_op  = w_illegal_op    & rst_n;

  // Mux selects are harmless during reset and show their IF values.
  assign PCSource = w_pc_source;
  assign IorD     = w_iord;
  assign MemToReg = w_mem_to_reg;
  assign RegDst   = w_reg_dst;
  assign ALUSrcA  = w_alu_src_a;
  assign ALUSrcB  = w_alu_src_b;
  assign ALUop    = w_alu_op;
  assign state    = r_state;

endmodule
